// File: rtl/difftest_pkg.sv
// Shared types and sizing helpers for the difftest commit queue.
package difftest_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned INST_BITS = 32;

  typedef struct packed {
    logic                 is_trap;
    logic [XLEN-1:0]      pc;
    logic [INST_BITS-1:0] inst;
    logic [XLEN-1:0]      wdata;
    logic [XLEN-1:0]      mstatus;
    logic                 check;
  } commit_entry_t;

  localparam int unsigned ENTRY_W = $bits(commit_entry_t);

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/difftest_lane_compactor.sv
// Packs sparse retire lanes plus an optional trap into a dense, program-ordered entry list.
module difftest_lane_compactor
  import difftest_pkg::*;
#(
  parameter int unsigned COMMIT_WIDTH = 2,
  localparam int unsigned CNT_W       = $clog2(COMMIT_WIDTH + 2)
) (
  input  logic [COMMIT_WIDTH-1:0]           in_valid,
  input  logic [XLEN*COMMIT_WIDTH-1:0]      in_pc,
  input  logic [INST_BITS*COMMIT_WIDTH-1:0] in_inst,
  input  logic [XLEN*COMMIT_WIDTH-1:0]      in_wdata,
  input  logic [XLEN*COMMIT_WIDTH-1:0]      in_mstatus,
  input  logic [COMMIT_WIDTH-1:0]           in_check,
  input  logic                              in_int_xcpt,
  input  logic [XLEN-1:0]                   in_cause,
  output commit_entry_t                     entries [COMMIT_WIDTH+1],
  output logic [CNT_W-1:0]                  count
);

  logic [CNT_W-1:0] idx;
  commit_entry_t    lane;

  always_comb begin
    for (int j = 0; j <= COMMIT_WIDTH; j++) entries[j] = '0;
    idx  = '0;
    lane = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (in_valid[i]) begin
        lane.is_trap = 1'b0;
        lane.pc      = in_pc[i*XLEN +: XLEN];
        lane.inst    = in_inst[i*INST_BITS +: INST_BITS];
        lane.wdata   = in_wdata[i*XLEN +: XLEN];
        lane.mstatus = in_mstatus[i*XLEN +: XLEN];
        lane.check   = in_check[i];
        for (int j = 0; j <= COMMIT_WIDTH; j++)
          if (CNT_W'(j) == idx) entries[j] = lane;
        idx = idx + CNT_W'(1);
      end
    end
    // Trap always lands after this cycle's instructions; cause rides in wdata.
    if (in_int_xcpt) begin
      lane         = '0;
      lane.is_trap = 1'b1;
      lane.wdata   = in_cause;
      for (int j = 0; j <= COMMIT_WIDTH; j++)
        if (CNT_W'(j) == idx) entries[j] = lane;
      idx = idx + CNT_W'(1);
    end
    count = idx;
  end

endmodule

// File: rtl/difftest_commit_queue.sv
// Elastic in-order buffer between core retire ports and the co-simulation checker.
module difftest_commit_queue
  import difftest_pkg::*;
#(
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned DRAIN_WIDTH  = 1,
  parameter int unsigned DEPTH        = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [COMMIT_WIDTH-1:0]           in_valid,
  input  logic                              in_hartid,
  input  logic [XLEN*COMMIT_WIDTH-1:0]      in_pc,
  input  logic [INST_BITS*COMMIT_WIDTH-1:0] in_inst,
  input  logic [XLEN*COMMIT_WIDTH-1:0]      in_wdata,
  input  logic [XLEN*COMMIT_WIDTH-1:0]      in_mstatus,
  input  logic [COMMIT_WIDTH-1:0]           in_check,
  input  logic                              in_int_xcpt,
  input  logic [XLEN-1:0]                   in_cause,
  output logic [DRAIN_WIDTH-1:0]            out_valid,
  output logic                              out_hartid,
  output logic [XLEN*DRAIN_WIDTH-1:0]       out_pc,
  output logic [INST_BITS*DRAIN_WIDTH-1:0]  out_inst,
  output logic [XLEN*DRAIN_WIDTH-1:0]       out_wdata,
  output logic [XLEN*DRAIN_WIDTH-1:0]       out_mstatus,
  output logic [DRAIN_WIDTH-1:0]            out_check,
  output logic                              out_int_xcpt,
  output logic [XLEN-1:0]                   out_cause,
  output logic                              stall,
  output logic                              overflow,
  output logic [31:0]                       drop_count
);

  localparam int unsigned PTR_W        = ptr_width(DEPTH);
  localparam int unsigned OCC_W        = occ_width(DEPTH);
  localparam int unsigned SUM_W        = OCC_W + 1;
  localparam int unsigned CNT_W        = $clog2(COMMIT_WIDTH + 2);
  localparam int unsigned OUT_W        = $clog2(DRAIN_WIDTH + 2);
  localparam int unsigned STALL_THRESH = DEPTH - 2 * (COMMIT_WIDTH + 1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr, rd_ptr_next, wr_ptr_next;
  logic [OCC_W-1:0]   occ, occ_after, occ_next;
  logic [SUM_W-1:0]   occ_sum;
  logic               accept;

  commit_entry_t      enq [COMMIT_WIDTH+1];
  logic [CNT_W-1:0]   n_in;
  commit_entry_t      head [DRAIN_WIDTH+1];
  commit_entry_t      trap_cand;
  logic [OUT_W-1:0]   k, n_out;
  logic               stop, trap_hit;

  difftest_lane_compactor #(.COMMIT_WIDTH(COMMIT_WIDTH)) u_compactor (
    .in_valid    (in_valid),
    .in_pc       (in_pc),
    .in_inst     (in_inst),
    .in_wdata    (in_wdata),
    .in_mstatus  (in_mstatus),
    .in_check    (in_check),
    .in_int_xcpt (in_int_xcpt),
    .in_cause    (in_cause),
    .entries     (enq),
    .count       (n_in)
  );

  always_comb begin
    for (int j = 0; j <= DRAIN_WIDTH; j++)
      head[j] = commit_entry_t'(mem[rd_ptr + PTR_W'(j)]);
  end

  // Emit leading non-trap entries, then a trap only if it directly follows them.
  always_comb begin
    out_valid   = '0;
    out_pc      = '0;
    out_inst    = '0;
    out_wdata   = '0;
    out_mstatus = '0;
    out_check   = '0;
    k           = '0;
    stop        = 1'b0;
    trap_cand   = '0;
    for (int j = 0; j < DRAIN_WIDTH; j++) begin
      if (!stop && reset && (OCC_W'(j) < occ) && !head[j].is_trap) begin
        out_valid[j]                        = 1'b1;
        out_pc[j*XLEN +: XLEN]              = head[j].pc;
        out_inst[j*INST_BITS +: INST_BITS]  = head[j].inst;
        out_wdata[j*XLEN +: XLEN]           = head[j].wdata;
        out_mstatus[j*XLEN +: XLEN]         = head[j].mstatus;
        out_check[j]                        = head[j].check;
        k                                   = k + OUT_W'(1);
      end else begin
        stop = 1'b1;
      end
    end
    for (int j = 0; j <= DRAIN_WIDTH; j++)
      if (OUT_W'(j) == k) trap_cand = head[j];
    trap_hit     = reset && (OCC_W'(k) < occ) && trap_cand.is_trap;
    out_int_xcpt = trap_hit;
    out_cause    = trap_hit ? trap_cand.wdata : '0;
    n_out        = k + OUT_W'(trap_hit);
  end

  // Atomic space check against post-dequeue occupancy.
  always_comb begin
    occ_after   = occ - OCC_W'(n_out);
    occ_sum     = SUM_W'(occ_after) + SUM_W'(n_in);
    accept      = occ_sum <= SUM_W'(DEPTH);
    occ_next    = accept ? OCC_W'(occ_sum) : occ_after;
    rd_ptr_next = rd_ptr + PTR_W'(n_out);
    wr_ptr_next = accept ? wr_ptr + PTR_W'(n_in) : wr_ptr;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      occ        <= '0;
      stall      <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
      out_hartid <= 1'b0;
    end else begin
      rd_ptr     <= rd_ptr_next;
      wr_ptr     <= wr_ptr_next;
      occ        <= occ_next;
      stall      <= occ_next >= OCC_W'(STALL_THRESH);
      out_hartid <= in_hartid;
      if (!accept) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 32'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset && accept) begin
      for (int j = 0; j <= COMMIT_WIDTH; j++)
        if (CNT_W'(j) < n_in) mem[wr_ptr + PTR_W'(j)] <= ENTRY_W'(enq[j]);
    end
  end

endmodule

// File: tb/tb_difftest_commit_queue.sv
// Directed bench for difftest_commit_queue (COMMIT_WIDTH=2, DRAIN_WIDTH=1, DEPTH=16).
module tb_difftest_commit_queue;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    in_valid;
  logic          in_hartid;
  logic [127:0]  in_pc;
  logic [63:0]   in_inst;
  logic [127:0]  in_wdata;
  logic [127:0]  in_mstatus;
  logic [1:0]    in_check;
  logic          in_int_xcpt;
  logic [63:0]   in_cause;
  logic [0:0]    out_valid;
  logic          out_hartid;
  logic [63:0]   out_pc;
  logic [31:0]   out_inst;
  logic [63:0]   out_wdata;
  logic [63:0]   out_mstatus;
  logic [0:0]    out_check;
  logic          out_int_xcpt;
  logic [63:0]   out_cause;
  logic          stall;
  logic          overflow;
  logic [31:0]   drop_count;

  int checks = 0;
  int failures = 0;
  int insts, traps;
  logic [63:0] last_pc;

  difftest_commit_queue #(.COMMIT_WIDTH(2), .DRAIN_WIDTH(1), .DEPTH(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_hartid    (in_hartid),
    .in_pc        (in_pc),
    .in_inst      (in_inst),
    .in_wdata     (in_wdata),
    .in_mstatus   (in_mstatus),
    .in_check     (in_check),
    .in_int_xcpt  (in_int_xcpt),
    .in_cause     (in_cause),
    .out_valid    (out_valid),
    .out_hartid   (out_hartid),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .out_wdata    (out_wdata),
    .out_mstatus  (out_mstatus),
    .out_check    (out_check),
    .out_int_xcpt (out_int_xcpt),
    .out_cause    (out_cause),
    .stall        (stall),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [63:0] pc0, input logic [63:0] pc1,
                       input logic x, input logic [63:0] cause);
    in_valid    = v;
    in_pc       = {pc1, pc0};
    in_inst     = {pc1[31:0] ^ 32'h13, pc0[31:0] ^ 32'h13};
    in_wdata    = {pc1 + 64'h10, pc0 + 64'h10};
    in_mstatus  = {64'ha00, 64'ha00};
    in_check    = v;
    in_int_xcpt = x;
    in_cause    = cause;
  endtask

  task automatic idle();
    drive(2'b00, 64'h0, 64'h0, 1'b0, 64'h0);
  endtask

  task automatic drain(output int n_inst, output int n_trap, output logic [63:0] lpc);
    n_inst = 0;
    n_trap = 0;
    lpc    = '0;
    for (int n = 0; n < 64; n++) begin
      if (out_valid == 1'b0 && !out_int_xcpt) return;
      if (out_valid[0]) begin
        n_inst++;
        lpc = out_pc;
      end
      if (out_int_xcpt) n_trap++;
      step();
    end
    check_eq("drain_bound", 64'(out_valid | out_int_xcpt), 64'h0);
  endtask

  initial begin
    reset     = 1'b0;
    in_hartid = 1'b0;
    idle();
    step();
    step();
    check_eq("rst_out_valid", 64'(out_valid), 64'h0);
    check_eq("rst_stall", 64'(stall), 64'h0);
    check_eq("rst_overflow", 64'(overflow), 64'h0);
    check_eq("rst_drop_count", 64'(drop_count), 64'h0);
    reset     = 1'b1;
    in_hartid = 1'b1;
    step();
    check_eq("post_rst_valid", 64'(out_valid), 64'h0);
    check_eq("post_rst_xcpt", 64'(out_int_xcpt), 64'h0);
    check_eq("hartid", 64'(out_hartid), 64'h1);

    // Single instruction on lane 1 only.
    drive(2'b10, 64'h0, 64'h80000004, 1'b0, 64'h0);
    step();
    idle();
    check_eq("t1_valid", 64'(out_valid), 64'h1);
    check_eq("t1_pc", out_pc, 64'h80000004);
    check_eq("t1_inst", 64'(out_inst), 64'h80000017);
    check_eq("t1_wdata", out_wdata, 64'h80000014);
    check_eq("t1_mstatus", out_mstatus, 64'ha00);
    check_eq("t1_check", 64'(out_check), 64'h1);
    step();
    check_eq("t1_empty", 64'(out_valid), 64'h0);

    // Two instructions plus trap: trap rides with the second instruction.
    drive(2'b11, 64'h100, 64'h104, 1'b1, 64'h8000000000000007);
    step();
    idle();
    check_eq("t2_c1_valid", 64'(out_valid), 64'h1);
    check_eq("t2_c1_pc", out_pc, 64'h100);
    check_eq("t2_c1_xcpt", 64'(out_int_xcpt), 64'h0);
    step();
    check_eq("t2_c2_valid", 64'(out_valid), 64'h1);
    check_eq("t2_c2_pc", out_pc, 64'h104);
    check_eq("t2_c2_xcpt", 64'(out_int_xcpt), 64'h1);
    check_eq("t2_c2_cause", out_cause, 64'h8000000000000007);
    step();
    check_eq("t2_empty_v", 64'(out_valid), 64'h0);
    check_eq("t2_empty_x", 64'(out_int_xcpt), 64'h0);

    // Trap at head alone, then two instructions.
    drive(2'b00, 64'h0, 64'h0, 1'b1, 64'hb);
    step();
    drive(2'b11, 64'h200, 64'h204, 1'b0, 64'h0);
    check_eq("t3_c1_valid", 64'(out_valid), 64'h0);
    check_eq("t3_c1_xcpt", 64'(out_int_xcpt), 64'h1);
    check_eq("t3_c1_cause", out_cause, 64'hb);
    step();
    idle();
    check_eq("t3_c2_valid", 64'(out_valid), 64'h1);
    check_eq("t3_c2_pc", out_pc, 64'h200);
    check_eq("t3_c2_xcpt", 64'(out_int_xcpt), 64'h0);
    step();
    check_eq("t3_c3_pc", out_pc, 64'h204);
    step();
    check_eq("t3_empty", 64'(out_valid), 64'h0);

    // Three entries per cycle against a 1-lane drain; stall ignored.
    for (int c = 1; c <= 10; c++) begin
      drive(2'b11, 64'h1000 + 64'(c) * 16, 64'h1004 + 64'(c) * 16, 1'b1, 64'(c));
      step();
      if (c == 5) check_eq("t4_stall_lo", 64'(stall), 64'h0);
      if (c == 6) check_eq("t4_stall_hi", 64'(stall), 64'h1);
      if (c == 9) check_eq("t4_no_ovf_yet", 64'(overflow), 64'h0);
      if (c == 10) begin
        check_eq("t4_overflow", 64'(overflow), 64'h1);
        check_eq("t4_drop_count", 64'(drop_count), 64'h1);
      end
    end
    idle();
    drain(insts, traps, last_pc);
    check_eq("t4_drain_insts", 64'(insts), 64'd9);
    check_eq("t4_drain_traps", 64'(traps), 64'd5);
    check_eq("t4_last_pc", last_pc, 64'h1094);
    check_eq("t4_stall_clear", 64'(stall), 64'h0);
    check_eq("t4_ovf_sticky", 64'(overflow), 64'h1);

    // Fill to 16, then accept one at full, then drop two at full.
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      drive(2'b11, 64'h2000 + 64'(c) * 8, 64'h2004 + 64'(c) * 8, 1'b0, 64'h0);
      step();
    end
    check_eq("t5_stall_full", 64'(stall), 64'h1);
    drive(2'b01, 64'h3000, 64'h0, 1'b0, 64'h0);
    step();
    check_eq("t5_accept_ovf", 64'(overflow), 64'h0);
    check_eq("t5_accept_drops", 64'(drop_count), 64'h0);
    drive(2'b11, 64'h3100, 64'h3104, 1'b0, 64'h0);
    step();
    idle();
    check_eq("t5_drop_ovf", 64'(overflow), 64'h1);
    check_eq("t5_drop_count", 64'(drop_count), 64'h1);
    drain(insts, traps, last_pc);
    check_eq("t5_drain_insts", 64'(insts), 64'd15);
    check_eq("t5_drain_traps", 64'(traps), 64'd0);
    check_eq("t5_last_pc", last_pc, 64'h3000);

    // Reset mid-burst clears everything.
    for (int c = 1; c <= 10; c++) begin
      drive(2'b11, 64'h4000 + 64'(c) * 8, 64'h4004 + 64'(c) * 8, 1'b0, 64'h0);
      step();
    end
    idle();
    check_eq("t6_pre_stall", 64'(stall), 64'h1);
    reset = 1'b0;
    #1;
    check_eq("t6_in_rst_valid", 64'(out_valid), 64'h0);
    step();
    reset = 1'b1;
    #1;
    check_eq("t6_c1_valid", 64'(out_valid), 64'h0);
    check_eq("t6_c1_xcpt", 64'(out_int_xcpt), 64'h0);
    check_eq("t6_stall", 64'(stall), 64'h0);
    check_eq("t6_overflow", 64'(overflow), 64'h0);
    check_eq("t6_drop_count", 64'(drop_count), 64'h0);
    step();
    check_eq("t6_c2_valid", 64'(out_valid), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
